iter_alu: RTL and testbench

Parametrised, handshaked successor to the single-cycle ALU units; one block covering add/sub/logic/shift, with status flags.
- Shifts execute iteratively, one bit per cycle; optional multiply is shift-add.
- Sits between the decode/operand-fetch stage and writeback in the multi-cycle datapath.
- Uses valid/ready on both input and output so the control FSM can stall on it.

---
 rtl/iter_alu.sv | 221 ++++++++++++++++++++++
 tb/tb_iter_alu.sv | 127 ++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Handshaked multi-cycle ALU: add/sub/logic in one cycle, shifts one bit per cycle.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 9.
module iter_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SLA = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd9;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_flag_z, r_flag_n, r_flag_c, r_flag_v, r_err;

    logic             w_accept, w_is_shift, w_is_mul, w_go_busy, w_last;
    logic [SHW-1:0]   w_n;
    logic [WIDTH:0]   w_sum, w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c, w_v, w_err;
    logic [WIDTH-1:0] w_step_res;
    logic             w_step_c;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] r_mcand, r_acc;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_acc_next, w_mq_next;
    assign w_is_mul = (op == OP_MUL);
`else
    assign w_is_mul = 1'b0;
`endif

    assign w_accept   = in_valid && in_ready;
    assign w_n        = (shamt != '0) ? shamt : b[SHW-1:0];
    assign w_is_shift = (op == OP_SLA) || (op == OP_SRA) || (op == OP_SRL);
    assign w_go_busy  = w_is_mul || (w_is_shift && (w_n != '0));
    assign w_last     = (r_cnt == CW'(1));
    assign w_sum      = {1'b0, a} + {1'b0, b};
    assign w_diff     = {1'b0, a} - {1'b0, b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        // NOTE: default every comb output first so no path can infer a latch.
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = w_go_busy ? BUSY : DONE;
            BUSY:    if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Single-cycle result; shifts reach here only with an effective amount of zero.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:                 w_res = a & b;
            OP_OR:                  w_res = a | b;
            OP_XOR:                 w_res = a ^ b;
            OP_NOT:                 w_res = ~a;
            OP_SLA, OP_SRA, OP_SRL: w_res = a;
`ifdef ALU_MUL_EN
            OP_MUL:                 w_res = '0;
`endif
            default:                w_err = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    // Partial product {r_acc, r_result} shifts right one bit per step.
    assign w_mul_sum  = {1'b0, r_acc} + (r_result[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = w_mul_sum[WIDTH:1];
    assign w_mq_next  = {w_mul_sum[0], r_result[WIDTH-1:1]};
`endif

    always_comb begin
        w_step_res = r_result;
        w_step_c   = 1'b0;
        case (r_op)
            OP_SLA: begin
                w_step_res = {r_result[WIDTH-2:0], 1'b0};
                w_step_c   = r_result[WIDTH-1];
            end
            OP_SRA: begin
                w_step_res = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
                w_step_c   = r_result[0];
            end
            OP_SRL: begin
                w_step_res = {1'b0, r_result[WIDTH-1:1]};
                w_step_c   = r_result[0];
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                w_step_res = w_mq_next;
                w_step_c   = |w_acc_next;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_op     <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_v <= 1'b0;
            r_err    <= 1'b0;
`ifdef ALU_MUL_EN
            r_mcand  <= '0;
            r_acc    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op  <= op;
                    r_err <= w_err;
                    if (w_go_busy) begin
                        r_result <= a;
                        r_cnt    <= CW'(w_n);
`ifdef ALU_MUL_EN
                        if (w_is_mul) begin
                            r_result <= b;
                            r_mcand  <= a;
                            r_acc    <= '0;
                            r_cnt    <= CW'(WIDTH);
                        end
`endif
                    end else begin
                        r_result <= w_res;
                        r_flag_z <= (w_res == '0);
                        r_flag_n <= w_res[WIDTH-1];
                        r_flag_c <= w_c;
                        r_flag_v <= w_v;
                    end
                end
                BUSY: begin
                    r_cnt    <= r_cnt - CW'(1);
                    r_result <= w_step_res;
`ifdef ALU_MUL_EN
                    r_acc    <= w_acc_next;
`endif
                    if (w_last) begin
                        r_flag_z <= (w_step_res == '0);
                        r_flag_n <= w_step_res[WIDTH-1];
                        r_flag_c <= w_step_c;
                        r_flag_v <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;
    assign flag_c = r_flag_c;
    assign flag_v = r_flag_v;
    assign err    = r_err;

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu (WIDTH=32); expectations follow ALU_MUL_EN.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  op;
    logic [31:0] a, b, result;
    logic [4:0]  shamt;
    logic        flag_z, flag_n, flag_c, flag_v, err;

    int n_vec = 0;
    int n_err = 0;

    iter_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .shamt(shamt), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .flag_z(flag_z), .flag_n(flag_n),
        .flag_c(flag_c), .flag_v(flag_v), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Flags packed as {z, n, c, v, err}.
    task automatic run_op(input string tag, input logic [3:0] f_op, input logic [31:0] f_a,
                          input logic [31:0] f_b, input logic [4:0] f_sh,
                          input logic [31:0] exp_res, input logic [4:0] exp_flags,
                          input int exp_lat, input int stall, input bit pulse);
        int lat;
        @(negedge clk);
        check({tag, "_rdy_pre"}, in_ready, 1);
        in_valid = 1'b1; op = f_op; a = f_a; b = f_b; shamt = f_sh;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (pulse) begin
                check({tag, "_rdy_busy"}, in_ready, 0);
                in_valid = 1'b1; op = 4'd0; a = $urandom; b = $urandom; shamt = 5'd3;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_flags"}, {flag_z, flag_n, flag_c, flag_v, err}, exp_flags);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, "_stall_vld"}, out_valid, 1);
            check({tag, "_stall_res"}, result, exp_res);
            check({tag, "_stall_flags"}, {flag_z, flag_n, flag_c, flag_v, err}, exp_flags);
            check({tag, "_stall_rdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_vld_post"}, out_valid, 0);
        check({tag, "_rdy_post"}, in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; shamt = '0;
        #12;
        check("reset_vld", out_valid, 0);
        check("reset_rdy", in_ready, 1);
        check("reset_res", result, 0);
        check("reset_flags", {flag_z, flag_n, flag_c, flag_v, err}, 5'b00000);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_ovf",  4'd0, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 5'b01010, 1, 0, 0);
        run_op("sub_brw",  4'd1, 32'd5,        32'd7,        5'd0,  32'hFFFFFFFE, 5'b01100, 1, 0, 0);
        run_op("xor_zero", 4'd4, 32'hA5A5A5A5, 32'hA5A5A5A5, 5'd0,  32'h00000000, 5'b10000, 1, 0, 0);
        run_op("sra4",     4'd7, 32'h80000010, 32'h0,        5'd4,  32'hF8000001, 5'b01000, 5, 0, 1);
        run_op("srl_b3",   4'd8, 32'h000000F0, 32'd3,        5'd0,  32'h0000001E, 5'b00000, 4, 0, 0);
        run_op("sla1",     4'd6, 32'h80000001, 32'h0,        5'd1,  32'h00000002, 5'b00100, 2, 0, 0);
        run_op("add_wrap", 4'd0, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 5'b10100, 1, 0, 0);
        run_op("sub_ovf",  4'd1, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 5'b00010, 1, 0, 0);
        run_op("and",      4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 5'b01000, 1, 0, 0);
        run_op("or",       4'd3, 32'h0000000F, 32'h000000F0, 5'd0,  32'h000000FF, 5'b00000, 1, 0, 0);
        run_op("not",      4'd5, 32'h00000000, 32'h12345678, 5'd0,  32'hFFFFFFFF, 5'b01000, 1, 0, 0);
        run_op("srl_n0",   4'd8, 32'h12345678, 32'hFFFFFFE0, 5'd0,  32'h12345678, 5'b00000, 1, 0, 0);
        run_op("sra31",    4'd7, 32'hC0000000, 32'h0,        5'd31, 32'hFFFFFFFF, 5'b01100, 32, 0, 0);
        run_op("sla31",    4'd6, 32'h00000001, 32'h0,        5'd31, 32'h80000000, 5'b01000, 32, 0, 0);
        run_op("stall",    4'd0, 32'd1,        32'd2,        5'd0,  32'h00000003, 5'b00000, 1, 3, 0);
`ifdef ALU_MUL_EN
        run_op("mul",      4'd9, 32'h00010000, 32'h00010001, 5'd0,  32'h00010000, 5'b00100, 33, 0, 0);
`else
        run_op("mul_ill",  4'd9, 32'h00010000, 32'h00010001, 5'd0,  32'h00000000, 5'b10001, 1, 0, 0);
`endif
        run_op("ill15",    4'd15, 32'h12345678, 32'h1,       5'd0,  32'h00000000, 5'b10001, 1, 0, 0);

        // Reset asserted in the middle of a long shift.
        @(negedge clk);
        in_valid = 1'b1; op = 4'd7; a = 32'h80000000; b = '0; shamt = 5'd20;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_busy", in_ready, 0);
        rst = 1'b1;
        #1;
        check("midrst_vld", out_valid, 0);
        check("midrst_rdy", in_ready, 1);
        check("midrst_res", result, 0);
        check("midrst_flags", {flag_z, flag_n, flag_c, flag_v, err}, 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        run_op("add_after_rst", 4'd0, 32'd2, 32'd3, 5'd0, 32'h00000005, 5'b00000, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
